// File: rtl/pio_target_responder.sv
// Endpoint PIO target: services decoded MemRd/MemWr requests against a local BAR A
// DW memory and emits completion descriptors for reads.
module pio_target_responder #(
  parameter int          TCQ          = 1,
  parameter logic [31:0] BAR_A_BASE   = 32'h1000_0000,
  parameter int          BAR_A_SIZE   = 1024,
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic        user_lnk_up,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [7:0]  req_tag,
  input  logic [15:0] req_id,
  input  logic [63:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_be,
  output logic        cpl_start,
  output logic        cpl_type,
  output logic [2:0]  cpl_status,
  output logic [7:0]  cpl_tag,
  output logic [15:0] cpl_req_id,
  output logic [15:0] cpl_cmpl_id,
  output logic [6:0]  cpl_lower_addr,
  output logic [31:0] cpl_data,
  input  logic        cpl_done,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [15:0] ur_count
);

  localparam int          IDX_W  = $clog2(BAR_A_SIZE);
  localparam logic [32:0] BAR_LO = {1'b0, BAR_A_BASE};
  localparam logic [32:0] BAR_HI = BAR_LO + 33'(4 * BAR_A_SIZE);
  localparam logic [2:0]  ST_SC  = 3'b000;
  localparam logic [2:0]  ST_UR  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FETCH,
    S_CPL,
    S_CPL_WAIT
  } state_t;

  state_t      state_reg;
  logic [2:0]  type_reg;
  logic [7:0]  tag_reg;
  logic [15:0] id_reg;
  logic [63:0] addr_reg;
  logic [31:0] data_reg;
  logic [3:0]  be_reg;

  logic             is_rsvd;
  logic             is_write;
  logic             upper_ok;
  logic             hit;
  logic [32:0]      addr33;
  logic [31:0]      bar_off;
  logic [IDX_W-1:0] mem_idx;
  logic [1:0]       lower_off;
  logic             mem_we;
  logic [3:0]       lane_we;

  logic [31:0] mem [BAR_A_SIZE];

  assign is_rsvd  = type_reg[2];
  assign is_write = type_reg[0];
  // 32-bit request types carry no meaningful upper address.
  assign upper_ok = !type_reg[1] || (addr_reg[63:32] == 32'h0);
  assign addr33   = {1'b0, addr_reg[31:0]};
  assign hit      = upper_ok && (addr33 >= BAR_LO) && (addr33 < BAR_HI);
  assign bar_off  = addr_reg[31:0] - BAR_A_BASE;
  assign mem_idx  = bar_off[IDX_W+1:2];

  always_comb begin
    lower_off = 2'd0;
    if (be_reg[0])      lower_off = 2'd0;
    else if (be_reg[1]) lower_off = 2'd1;
    else if (be_reg[2]) lower_off = 2'd2;
    else if (be_reg[3]) lower_off = 2'd3;
  end

  // A write commits only if neither reset nor link loss is sampled on that edge.
  assign mem_we = (state_reg == S_DECODE) && !reset && user_lnk_up &&
                  !is_rsvd && is_write && hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = mem_we && be_reg[gi];
  end

  always_ff @(posedge user_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) mem[mem_idx][b*8 +: 8] <= data_reg[b*8 +: 8];
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      req_ready      <= 1'b0;
      cpl_start      <= 1'b0;
      cpl_type       <= 1'b0;
      cpl_status     <= 3'b000;
      cpl_tag        <= 8'h00;
      cpl_req_id     <= 16'h0000;
      cpl_cmpl_id    <= 16'h0000;
      cpl_lower_addr <= 7'h00;
      cpl_data       <= 32'h0;
      wr_count       <= 16'h0;
      rd_count       <= 16'h0;
      ur_count       <= 16'h0;
      type_reg       <= 3'b000;
      tag_reg        <= 8'h00;
      id_reg         <= 16'h0000;
      addr_reg       <= 64'h0;
      data_reg       <= 32'h0;
      be_reg         <= 4'h0;
    end else if (!user_lnk_up) begin
      // Link loss abandons any in-flight request; counters survive.
      state_reg      <= S_IDLE;
      req_ready      <= 1'b0;
      cpl_start      <= 1'b0;
      cpl_type       <= 1'b0;
      cpl_status     <= 3'b000;
      cpl_tag        <= 8'h00;
      cpl_req_id     <= 16'h0000;
      cpl_cmpl_id    <= 16'h0000;
      cpl_lower_addr <= 7'h00;
      cpl_data       <= 32'h0;
    end else begin
      req_ready <= 1'b0;
      cpl_start <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            type_reg  <= req_type;
            tag_reg   <= req_tag;
            id_reg    <= req_id;
            addr_reg  <= req_addr;
            data_reg  <= req_data;
            be_reg    <= req_be;
            state_reg <= S_DECODE;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_DECODE: begin
          if (is_rsvd || (is_write && !hit)) begin
            ur_count  <= sat_inc(ur_count);
            state_reg <= S_IDLE;
            req_ready <= 1'b1;
          end else if (is_write) begin
            wr_count  <= sat_inc(wr_count);
            state_reg <= S_IDLE;
            req_ready <= 1'b1;
          end else if (hit) begin
            state_reg <= S_FETCH;
          end else begin
            ur_count       <= sat_inc(ur_count);
            cpl_type       <= 1'b0;
            cpl_status     <= ST_UR;
            cpl_tag        <= tag_reg;
            cpl_req_id     <= id_reg;
            cpl_cmpl_id    <= COMPLETER_ID;
            cpl_lower_addr <= {addr_reg[6:2], lower_off};
            cpl_data       <= 32'h0;
            cpl_start      <= 1'b1;
            state_reg      <= S_CPL;
          end
        end
        S_FETCH: begin
          rd_count       <= sat_inc(rd_count);
          cpl_type       <= 1'b1;
          cpl_status     <= ST_SC;
          cpl_tag        <= tag_reg;
          cpl_req_id     <= id_reg;
          cpl_cmpl_id    <= COMPLETER_ID;
          cpl_lower_addr <= {addr_reg[6:2], lower_off};
          cpl_data       <= mem[mem_idx];
          cpl_start      <= 1'b1;
          state_reg      <= S_CPL;
        end
        S_CPL: begin
          state_reg <= S_CPL_WAIT;
        end
        S_CPL_WAIT: begin
          if (cpl_done) begin
            state_reg <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  logic unused_sink;
  assign unused_sink = ^{bar_off[31:IDX_W+2], bar_off[1:0]} ^ (TCQ != 0);

endmodule

// File: doc/pio_target_responder.md
Name: pio_target_responder

Overview:
Endpoint-side PIO target that answers the MemRd/MemWr requests issued by the root-port controller. It accepts decoded request TLP fields from the RX parser and services them against a local BAR A DW memory. Reads produce completion descriptors for the TX completion generator; writes are posted and produce no completion. It sits between the endpoint RX TLP decoder and the TX completion engine.

Parameters:
TCQ, 1, simulation clock-to-q delay
BAR_A_BASE, 32'h1000_0000, BAR A byte base address
BAR_A_SIZE, 1024, BAR A size in DW (power of 2)
COMPLETER_ID, 16'h0100, bus/dev/func placed in completions

Ports:
user_clk  in  1  clock
reset  in  1  synchronous, active-high reset
user_lnk_up  in  1  link up; low forces idle
req_valid  in  1  request fields valid
req_ready  out  1  block can accept a request
req_type  in  3  000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64, 1xx reserved
req_tag  in  8  request tag
req_id  in  16  requester ID
req_addr  in  64  byte address (upper 32 ignored for *32 types)
req_data  in  32  write data DW
req_be  in  4  first-DW byte enables
cpl_start  out  1  one-cycle pulse: completion descriptor valid
cpl_type  out  1  0 Cpl (no data), 1 CplD
cpl_status  out  3  000 SC, 001 UR
cpl_tag  out  8  echoed req_tag
cpl_req_id  out  16  echoed req_id
cpl_cmpl_id  out  16  COMPLETER_ID
cpl_lower_addr  out  7  completion lower address
cpl_data  out  32  read data (0 for Cpl)
cpl_done  in  1  TX engine finished sending completion
wr_count  out  16  accepted in-range writes, saturating
rd_count  out  16  in-range reads completed, saturating
ur_count  out  16  unsupported/out-of-range requests, saturating

Behaviour:
- Reset: state IDLE; req_ready 0; cpl_start 0; all cpl_* 0; all counters 0. Memory contents are not cleared.
- States: IDLE, DECODE, FETCH, CPL, CPL_WAIT.
- req_ready = (state==IDLE) && user_lnk_up, registered.
- IDLE: on req_valid && req_ready, capture all req_* and go to DECODE.
- Hit condition: the effective upper address is 0 (always 0 for *32 types), and BAR_A_BASE <= addr[31:0] < BAR_A_BASE + 4*BAR_A_SIZE. Compare in 33 bits to avoid wrap.
- Memory index = (addr[31:0] - BAR_A_BASE) >> 2.
- DECODE actions:
  - Write hit: byte-masked write into memory at the end of the cycle; wr_count++; go to IDLE.
  - Write miss: drop; ur_count++; go to IDLE.
  - Reserved type: drop; ur_count++; go to IDLE; no completion.
  - Read hit: go to FETCH.
  - Read miss: ur_count++; load Cpl descriptor with status UR, cpl_data 0; go to CPL.
- FETCH: synchronous memory read registered into cpl_data. Load CplD descriptor with status SC; rd_count++; go to CPL.
- cpl_lower_addr = {addr[6:2], off}. off is the index of the lowest set bit of req_be, or 00 if req_be is 0.
- CPL: cpl_start=1 for exactly this cycle; go to CPL_WAIT.
- CPL_WAIT: hold all cpl_* stable until cpl_done; then go to IDLE. cpl_done in any other state is ignored.
- Request throughput:
  - Write: next accept is possible 2 cycles after accept.
  - Read hit: accept → cpl_start is 3 cycles.
  - Read miss: accept → cpl_start is 2 cycles.
- Requests are strictly serialized, so read-after-write to the same address returns the new data.
- user_lnk_up low in any state: go to IDLE next cycle, cpl_start 0, any pending completion discarded. Counters and memory are retained; only reset clears counters.
- Reset asserted mid-transaction: same as the reset values above; no partial memory write occurs after reset is sampled.
- Counters saturate at 16'hFFFF.

Test Plan:
1. MemWr32 0x1000_0000 data 0x12345678 be F, then MemRd32 tag 0x05 id 0x0000 → cpl_start 3 cycles after the read accept; CplD, SC, data 0x12345678, tag 05, cmpl_id 0x0100, lower_addr 0x00; wr_count=1, rd_count=1.
2. Write 0xAABBCCDD be F to 0x1000_0010, then 0x11223344 be 0101 → read returns 0xAA22CC44, lower_addr 0x10.
3. MemRd32 0x1000_1000 (SIZE 1024) → Cpl, UR, cpl_data 0, ur_count=1. MemWr32 to the same address → no cpl_start, ur_count=2, memory unchanged. req_type 3'b100 → no cpl_start, ur_count=3.
4. MemRd64 addr 0x1_1000_0000 → UR. MemRd64 addr 0x0_1000_0FFC → SC with stored data; last DW boundary hits.
5. cpl_done held off 10 cycles with req_valid continuously high → req_ready stays 0 and cpl_* stay stable; next request is accepted the first cycle req_ready is 1 after returning to IDLE; exactly one cpl_start per read.
6. Drop user_lnk_up during CPL_WAIT → IDLE, no further cpl_start; after link up, a read of the previously written address returns the old data and the counters are unchanged.
